// File: rtl/data_sram_bridge.sv
// Data-side bridge: turns MEM's one-cycle RAM strobes into a req/addr_ok/data_ok bus transaction.
// Optional DBRIDGE_POSTED_WRITE_EN: stores retire on addr_ok and complete in the background.
module data_sram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_read_enable_i,
    input  logic [31:0] ram_read_addr_i,
    input  logic        ram_write_enable_i,
    input  logic [31:0] ram_write_addr_i,
    input  logic [31:0] ram_write_data_i,
    input  logic [3:0]  ram_write_select_i,
    input  logic        mem_exception_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic [31:0] ram_read_data_o,
    output logic        stall_req_o,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        cancel, cancel_nxt;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_buf;

    logic        strobe_ok;
    logic [1:0]  st_size;
    logic [1:0]  st_off;
    logic        access;
    logic        issue_ok;
    logic        can_issue;
    logic        posted_store;
    logic        latch_req;
    logic        load_rd;
    logic        stall_c;
    logic        unused_addr_lsb;

    // Store address low bits are rebuilt from the byte strobe instead.
    assign unused_addr_lsb = ^ram_write_addr_i[1:0];

    always_comb begin
        strobe_ok = 1'b1;
        st_size   = 2'd0;
        st_off    = 2'd0;
        case (ram_write_select_i)
            4'b0001: st_off = 2'd0;
            4'b0010: st_off = 2'd1;
            4'b0100: st_off = 2'd2;
            4'b1000: st_off = 2'd3;
            4'b0011: st_size = 2'd1;
            4'b1100: begin
                st_size = 2'd1;
                st_off  = 2'd2;
            end
            4'b1111: st_size = 2'd2;
            default: strobe_ok = 1'b0;
        endcase
    end

    assign access   = (ram_read_enable_i | ram_write_enable_i) & ~mem_exception_i & ~flush_i;
    assign issue_ok = access & (~ram_write_enable_i | strobe_ok);

`ifdef DBRIDGE_POSTED_WRITE_EN
    logic pending_wr;

    assign can_issue    = issue_ok & ~pending_wr;
    assign posted_store = wr_q;

    // Only one store may be in flight, so any data_ok seen while pending belongs to it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_wr <= 1'b0;
        end else if (state == REQ && data_addr_ok_i && wr_q) begin
            pending_wr <= 1'b1;
        end else if (data_data_ok_i) begin
            pending_wr <= 1'b0;
        end
    end
`else
    assign can_issue    = issue_ok;
    assign posted_store = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        cancel_nxt = cancel;
        latch_req  = 1'b0;
        load_rd    = 1'b0;
        stall_c    = 1'b0;
        case (state)
            IDLE: begin
                stall_c = issue_ok;
                if (can_issue) begin
                    state_nxt  = REQ;
                    latch_req  = 1'b1;
                    cancel_nxt = 1'b0;
                end
            end
            REQ: begin
                stall_c = ~cancel | issue_ok;
                if (flush_i && !posted_store) cancel_nxt = 1'b1;
                if (data_addr_ok_i) state_nxt = posted_store ? DONE : WAIT;
            end
            WAIT: begin
                stall_c = ~cancel | issue_ok;
                if (data_data_ok_i) begin
                    if (cancel || flush_i) begin
                        state_nxt  = IDLE;
                        cancel_nxt = 1'b0;
                    end else begin
                        state_nxt = DONE;
                        load_rd   = ~wr_q;
                    end
                end else if (flush_i) begin
                    cancel_nxt = 1'b1;
                end
            end
            DONE: begin
                if (flush_i || !stall_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cancel  <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_buf  <= 32'd0;
        end else begin
            state  <= state_nxt;
            cancel <= cancel_nxt;
            if (latch_req) begin
                wr_q    <= ram_write_enable_i;
                size_q  <= ram_write_enable_i ? st_size : 2'd2;
                addr_q  <= ram_write_enable_i ? {ram_write_addr_i[31:2], st_off} : ram_read_addr_i;
                wdata_q <= ram_write_data_i;
            end
            if (load_rd) rd_buf <= data_rdata_i;
        end
    end

    assign data_req_o      = (state == REQ);
    assign data_wr_o       = wr_q;
    assign data_size_o     = size_q;
    assign data_addr_o     = addr_q;
    assign data_wdata_o    = wdata_q;
    assign ram_read_data_o = rd_buf;
    assign stall_req_o     = stall_c & rst;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge; follows DBRIDGE_POSTED_WRITE_EN when defined.
`timescale 1ns/1ps
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_read_enable_i = 1'b0;
    logic [31:0] ram_read_addr_i = 32'd0;
    logic        ram_write_enable_i = 1'b0;
    logic [31:0] ram_write_addr_i = 32'd0;
    logic [31:0] ram_write_data_i = 32'd0;
    logic [3:0]  ram_write_select_i = 4'd0;
    logic        mem_exception_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [31:0] ram_read_data_o;
    logic        stall_req_o;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i = 1'b0;
    logic        data_data_ok_i = 1'b0;
    logic [31:0] data_rdata_i = 32'd0;

    always #5 clk = ~clk;

    data_sram_bridge dut (
        .clk                (clk),
        .rst                (rst),
        .ram_read_enable_i  (ram_read_enable_i),
        .ram_read_addr_i    (ram_read_addr_i),
        .ram_write_enable_i (ram_write_enable_i),
        .ram_write_addr_i   (ram_write_addr_i),
        .ram_write_data_i   (ram_write_data_i),
        .ram_write_select_i (ram_write_select_i),
        .mem_exception_i    (mem_exception_i),
        .flush_i            (flush_i),
        .stall_i            (stall_i),
        .ram_read_data_o    (ram_read_data_o),
        .stall_req_o        (stall_req_o),
        .data_req_o         (data_req_o),
        .data_wr_o          (data_wr_o),
        .data_size_o        (data_size_o),
        .data_addr_o        (data_addr_o),
        .data_wdata_o       (data_wdata_o),
        .data_addr_ok_i     (data_addr_ok_i),
        .data_data_ok_i     (data_data_ok_i),
        .data_rdata_i       (data_rdata_i)
    );

`ifdef DBRIDGE_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;
    int req_cnt = 0;
    bit chk_en = 1'b0;
    bit chk_stall = 1'b1;
    bit exp_zero = 1'b0;
    logic        exp_stall = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_wr = 1'b0;
    logic [1:0]  exp_size = 2'd0;
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_wdata = 32'd0;
    logic [31:0] model_rd = 32'd0;
    logic        cap_wr = 1'b0;
    logic [1:0]  cap_size = 2'd0;
    logic [31:0] cap_addr = 32'd0;
    logic [3:0]  legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bus size from the number of enabled lanes; offset is the lowest enabled lane.
    function automatic logic [1:0] strobe_size(input logic [3:0] s);
        int n;
        n = $countones(s);
        return (n == 4) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [31:0] strobe_off(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return 32'(i);
        return 32'd0;
    endfunction

    always @(negedge clk) begin
        if (stall_req_o === 1'b1) stall_cnt++;
        if (data_req_o === 1'b1) req_cnt++;
        if (chk_en) begin
            if (chk_stall) chk("stall_req_o", 32'(stall_req_o), 32'(exp_stall));
            chk("data_req_o", 32'(data_req_o), 32'(exp_req));
            if (exp_zero) begin
                chk("reset_wr", 32'(data_wr_o), 32'd0);
                chk("reset_size", 32'(data_size_o), 32'd0);
                chk("reset_addr", data_addr_o, 32'd0);
                chk("reset_wdata", data_wdata_o, 32'd0);
            end else if (exp_req) begin
                chk("req_wr", 32'(data_wr_o), 32'(exp_wr));
                chk("req_size", 32'(data_size_o), 32'(exp_size));
                chk("req_addr", data_addr_o, exp_addr);
                chk("req_wdata", data_wdata_o, exp_wdata);
            end
            chk("ram_read_data_o", ram_read_data_o, model_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        ram_read_enable_i  = 1'b0;
        ram_write_enable_i = 1'b0;
        ram_write_select_i = 4'd0;
        mem_exception_i    = 1'b0;
        flush_i            = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_mem();
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        chk_stall = 1'b1;
        repeat (n) tick();
    endtask

    task automatic present(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdat,
                           input logic [3:0] strb);
        ram_read_enable_i  = !is_wr;
        ram_write_enable_i = is_wr;
        ram_read_addr_i    = addr;
        ram_write_addr_i   = addr;
        ram_write_data_i   = wdat;
        ram_write_select_i = strb;
        exp_wr    = is_wr;
        exp_size  = is_wr ? strobe_size(strb) : 2'd2;
        exp_addr  = is_wr ? addr + strobe_off(strb) : addr;
        exp_wdata = wdat;
    endtask

    // One access: wa idle bus cycles before addr_ok, wd idle cycles before data_ok, hs stalled DONE cycles.
    task automatic run_access(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdat,
                              input logic [3:0] strb, input logic [31:0] rdat,
                              input int wa, input int wd, input int hs);
        present(is_wr, addr, wdat, strb);
        exp_stall = 1'b1;
        exp_req   = 1'b0;
        chk_stall = 1'b1;
        stall_cnt = 0;
        req_cnt   = 0;
        tick();
        for (int i = 0; i <= wa; i++) begin
            exp_req = 1'b1;
            data_addr_ok_i = (i == wa);
            if (i == 0) begin
                cap_wr   = data_wr_o;
                cap_size = data_size_o;
                cap_addr = data_addr_o;
            end
            tick();
        end
        data_addr_ok_i = 1'b0;
        exp_req = 1'b0;
        if (is_wr && POSTED) begin
            exp_stall = 1'b0;
            for (int i = 0; i <= wd; i++) begin
                data_data_ok_i = (i == wd);
                data_rdata_i = $urandom;
                if (i == 1) clear_mem();
                tick();
            end
            data_data_ok_i = 1'b0;
            clear_mem();
        end else begin
            for (int i = 0; i <= wd; i++) begin
                data_data_ok_i = (i == wd);
                data_rdata_i = (i == wd) ? rdat : $urandom;
                tick();
            end
            data_data_ok_i = 1'b0;
            if (!is_wr) model_rd = rdat;
            exp_stall = 1'b0;
            for (int i = 0; i <= hs; i++) begin
                stall_i = (i < hs);
                tick();
            end
            stall_i = 1'b0;
            clear_mem();
        end
    endtask

    // A load flushed at busy cycle fpos; its response is dropped and an optional new load follows.
    task automatic run_flush(input logic [31:0] addr1, input logic [31:0] rdat1, input int wa, input int wd,
                             input int fpos, input bit newacc, input logic [31:0] addr2,
                             input logic [31:0] rdat2, input int wa2, input int wd2);
        present(1'b0, addr1, $urandom, 4'hf);
        exp_stall = 1'b1;
        exp_req   = 1'b0;
        chk_stall = 1'b1;
        tick();
        for (int k = 0; k <= wa + wd + 1; k++) begin
            exp_req        = (k <= wa);
            data_addr_ok_i = (k == wa);
            data_data_ok_i = (k == wa + wd + 1);
            data_rdata_i   = rdat1;
            flush_i        = (k == fpos);
            chk_stall      = (k != fpos);
            if (k > fpos) exp_stall = newacc;
            if (k == fpos + 1) begin
                if (newacc) begin
                    ram_read_enable_i  = 1'b1;
                    ram_write_enable_i = 1'b0;
                    ram_read_addr_i    = addr2;
                end else begin
                    clear_mem();
                end
            end
            tick();
        end
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        flush_i   = 1'b0;
        chk_stall = 1'b1;
        exp_req   = 1'b0;
        if (newacc) run_access(1'b0, addr2, $urandom, 4'hf, rdat2, wa2, wd2, 0);
        else idle(2);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        chk_en = 1'b1;
        exp_zero = 1'b1;
        tick();
        exp_zero = 1'b0;

        run_access(1'b0, 32'h0000_1000, 32'd0, 4'hf, 32'hDEAD_BEEF, 0, 0, 0);
        chk("t1_stall_cycles", 32'(stall_cnt), 32'd3);
        chk("t1_rdata", ram_read_data_o, 32'hDEAD_BEEF);

        run_access(1'b1, 32'h0000_1000, 32'h5A5A_5A5A, 4'b0100, 32'h0, 0, 0, 0);
        chk("t2_size", 32'(cap_size), 32'd0);
        chk("t2_addr", cap_addr, 32'h0000_1002);
        chk("t2_wr", 32'(cap_wr), 32'd1);
        chk("t2_stall_cycles", 32'(stall_cnt), POSTED ? 32'd2 : 32'd3);
        chk("t2_rdata_kept", ram_read_data_o, 32'hDEAD_BEEF);

        run_access(1'b0, 32'h0000_1800, 32'h0, 4'hf, 32'hCAFE_F00D, 4, 2, 0);
        chk("t3_stall_cycles", 32'(stall_cnt), 32'd9);

        run_flush(32'h0000_1C00, 32'h1111_1111, 0, 1, 1, 1'b1, 32'h0000_2000, 32'h2222_2222, 0, 0);
        chk("t4_rdata", ram_read_data_o, 32'h2222_2222);

        run_access(1'b0, 32'h0000_2400, 32'h0, 4'hf, 32'h3333_3333, 0, 0, 5);
        chk("t5_req_cycles", 32'(req_cnt), 32'd1);
        chk("t5_stall_cycles", 32'(stall_cnt), 32'd3);
        chk("t5_rdata", ram_read_data_o, 32'h3333_3333);

        present(1'b0, 32'h0000_3000, 32'hA5A5_A5A5, 4'hf);
        exp_stall = 1'b1;
        tick();
        exp_req = 1'b1;
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        exp_req = 1'b0;
        rst = 1'b0;
        chk_stall = 1'b0;
        tick();
        rst = 1'b1;
        clear_mem();
        chk_stall = 1'b1;
        exp_stall = 1'b0;
        exp_zero = 1'b1;
        model_rd = 32'd0;
        tick();
        exp_zero = 1'b0;
        run_access(1'b0, 32'h0000_3100, 32'h0, 4'hf, 32'h0BAD_F00D, 1, 1, 0);

        present(1'b0, 32'h0000_4000, 32'h0, 4'hf);
        mem_exception_i = 1'b1;
        exp_stall = 1'b0;
        exp_req = 1'b0;
        repeat (3) tick();
        present(1'b1, 32'h0000_4000, 32'h1234_5678, 4'b0101);
        chk_stall = 1'b0;
        repeat (3) tick();
        present(1'b0, 32'h0000_4000, 32'h0, 4'hf);
        flush_i = 1'b1;
        chk_stall = 1'b1;
        tick();
        idle(2);

`ifdef DBRIDGE_POSTED_WRITE_EN
        present(1'b1, 32'h0000_5000, 32'h7777_7777, 4'b0011);
        exp_stall = 1'b1;
        tick();
        exp_req = 1'b1;
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        exp_req = 1'b0;
        exp_stall = 1'b0;
        tick();
        present(1'b0, 32'h0000_5100, 32'h0, 4'hf);
        exp_stall = 1'b1;
        tick();
        data_data_ok_i = 1'b1;
        tick();
        data_data_ok_i = 1'b0;
        run_access(1'b0, 32'h0000_5100, 32'h0, 4'hf, 32'h4444_4444, 0, 0, 0);
        chk("posted_then_load_rdata", ram_read_data_o, 32'h4444_4444);
`endif

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            int sel;
            int wa;
            int wd;
            a   = $urandom & 32'hFFFF_FFFC;
            d   = $urandom;
            sel = $urandom_range(0, 9);
            wa  = $urandom_range(0, 3);
            wd  = $urandom_range(0, 3);
            if (sel < 2)
                run_flush(a, d, wa, wd, $urandom_range(0, wa + wd), 1'($urandom_range(0, 1)),
                          a ^ 32'h0000_1000, ~d, $urandom_range(0, 2), $urandom_range(0, 2));
            else if (sel < 6)
                run_access(1'b0, a, d, 4'hf, $urandom, wa, wd, $urandom_range(0, 2));
            else
                run_access(1'b1, a, d, legal[$urandom_range(0, 6)], $urandom, wa, wd, $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
